// File: rtl/nfc_pkg.sv
// Shared definitions for the NFC command dispatcher: FSM state encoding,
// ACG field widths and the idle values driven when no executor owns the ACG.
package nfc_pkg;

    localparam int ACG_CMD_W = 8;
    localparam int ACG_OPT_W = 3;
    localparam int ACG_NOD_W = 16;
    localparam int ACG_CAD_W = 40;

    typedef enum logic [2:0] {
        S_IDLE   = 3'b001,
        S_ACTIVE = 3'b010,
        S_DONE   = 3'b100
    } disp_state_e;

    localparam logic [ACG_CMD_W-1:0] ACG_IDLE_CMD    = 8'h00;
    localparam logic [ACG_OPT_W-1:0] ACG_IDLE_OPT    = 3'b000;
    localparam logic [ACG_NOD_W-1:0] ACG_IDLE_NOD    = 16'h0000;
    localparam logic                 ACG_IDLE_CASEL  = 1'b1;
    localparam logic [ACG_CAD_W-1:0] ACG_IDLE_CADATA = 40'h0;

endpackage

// File: rtl/nfc_lowest_onehot.sv
// Priority encoder: isolates the lowest set request bit as a one-hot vector
// and flags when more than one request bit is set.
module nfc_lowest_onehot #(
    parameter int Width = 4
) (
    input  logic [Width-1:0] iRequest,
    output logic [Width-1:0] oOneHot,
    output logic             oMultiple
);

    // Two's-complement trick: x & -x keeps only the lowest set bit.
    assign oOneHot   = iRequest & (~iRequest + {{(Width-1){1'b0}}, 1'b1});
    assign oMultiple = |(iRequest & ~oOneHot);

endmodule

// File: rtl/nfc_command_dispatcher.sv
// Grants the shared atomic command generator port to one executor at a time.
// Optional watchdog with abort is built when NFC_DISPATCH_TIMEOUT_EN is defined.
module nfc_command_dispatcher
    import nfc_pkg::*;
#(
    parameter int          NumberOfWays      = 4,
    parameter int          NumberOfExecutors = 4,
    parameter logic [31:0] TimeoutCycles     = 32'd1_000_000
) (
    input  logic                                      iSystemClock,
    input  logic                                      iReset,
    input  logic                                      iCMDValid,
    output logic                                      oCMDReady,
    input  logic [NumberOfExecutors-1:0]              iExecStart,
    input  logic [NumberOfExecutors-1:0]              iExecCMDReady,
    input  logic [NumberOfExecutors-1:0]              iExecLastStep,
    input  logic [ACG_CMD_W*NumberOfExecutors-1:0]    iExecCommand,
    input  logic [ACG_OPT_W*NumberOfExecutors-1:0]    iExecCommandOption,
    input  logic [NumberOfWays*NumberOfExecutors-1:0] iExecTargetWay,
    input  logic [ACG_NOD_W*NumberOfExecutors-1:0]    iExecNumOfData,
    input  logic [NumberOfExecutors-1:0]              iExecCASelect,
    input  logic [ACG_CAD_W*NumberOfExecutors-1:0]    iExecCAData,
    output logic [NumberOfExecutors-1:0]              oExecAbort,
    output logic [ACG_CMD_W-1:0]                      oACG_Command,
    output logic [ACG_OPT_W-1:0]                      oACG_CommandOption,
    output logic [NumberOfWays-1:0]                   oACG_TargetWay,
    output logic [ACG_NOD_W-1:0]                      oACG_NumOfData,
    output logic                                      oACG_CASelect,
    output logic [ACG_CAD_W-1:0]                      oACG_CAData,
    output logic [NumberOfExecutors-1:0]              oOwner,
    output logic                                      oBusy,
    output logic                                      oCmdDone,
    output logic                                      oCmdError,
    output logic                                      oTimeout
);

    disp_state_e                  state_q;
    logic [NumberOfExecutors-1:0] owner_q, owner_d;
    logic [NumberOfExecutors-1:0] abort_q;
    logic                         done_q, error_q, timeout_q;
    logic                         multi_start, accept, owner_last, timeout_hit;

    nfc_lowest_onehot #(
        .Width(NumberOfExecutors)
    ) u_owner_sel (
        .iRequest (iExecStart),
        .oOneHot  (owner_d),
        .oMultiple(multi_start)
    );

    assign oCMDReady  = (state_q == S_IDLE) && !iReset && (&iExecCMDReady);
    assign accept     = iCMDValid && oCMDReady;
    assign owner_last = |(iExecLastStep & owner_q);

`ifdef NFC_DISPATCH_TIMEOUT_EN
    logic [31:0] count_q, count_d;

    // Any non-ACTIVE cycle zeroes the count, so it starts at 0 on entry.
    assign count_d     = (state_q == S_ACTIVE) ? count_q + 32'd1 : 32'd0;
    assign timeout_hit = (state_q == S_ACTIVE) && (count_q == TimeoutCycles - 32'd1);

    always_ff @(posedge iSystemClock) begin
        if (iReset) count_q <= 32'd0;
        else        count_q <= count_d;
    end
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = TimeoutCycles;
    assign timeout_hit           = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            state_q   <= S_IDLE;
            owner_q   <= '0;
            abort_q   <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            abort_q   <= '0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (iExecStart == '0) begin
                            error_q <= 1'b1;
                        end else begin
                            owner_q <= owner_d;
                            error_q <= multi_start;
                            state_q <= S_ACTIVE;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (owner_last) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (timeout_hit) begin
                        timeout_q <= 1'b1;
                        abort_q   <= owner_q;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    owner_q <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    owner_q <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign oOwner     = owner_q;
    assign oBusy      = (state_q != S_IDLE);
    assign oCmdDone   = done_q;
    assign oCmdError  = error_q;
    assign oTimeout   = timeout_q;
    assign oExecAbort = abort_q;

    // NOTE: every output gets its idle default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        oACG_Command       = ACG_IDLE_CMD;
        oACG_CommandOption = ACG_IDLE_OPT;
        oACG_TargetWay     = '0;
        oACG_NumOfData     = ACG_IDLE_NOD;
        oACG_CASelect      = ACG_IDLE_CASEL;
        oACG_CAData        = ACG_IDLE_CADATA;
        if (state_q == S_ACTIVE && !iReset) begin
            for (int i = 0; i < NumberOfExecutors; i++) begin
                if (owner_q[i]) begin
                    oACG_Command       = iExecCommand[ACG_CMD_W*i +: ACG_CMD_W];
                    oACG_CommandOption = iExecCommandOption[ACG_OPT_W*i +: ACG_OPT_W];
                    oACG_TargetWay     = iExecTargetWay[NumberOfWays*i +: NumberOfWays];
                    oACG_NumOfData     = iExecNumOfData[ACG_NOD_W*i +: ACG_NOD_W];
                    oACG_CASelect      = iExecCASelect[i];
                    oACG_CAData        = iExecCAData[ACG_CAD_W*i +: ACG_CAD_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_nfc_command_dispatcher.sv
// Directed bench for nfc_command_dispatcher; pulse outputs are checked by a
// scoreboard monitor, steady-state outputs by direct comparisons.
module tb_nfc_command_dispatcher;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [N-1:0]   exec_start, exec_ready, exec_last, exec_casel;
    logic [8*N-1:0] exec_cmd;
    logic [3*N-1:0] exec_opt;
    logic [W*N-1:0] exec_way;
    logic [16*N-1:0] exec_nod;
    logic [40*N-1:0] exec_cad;
    logic [N-1:0]   abort, owner;
    logic [7:0]     acg_cmd;
    logic [2:0]     acg_opt;
    logic [W-1:0]   acg_way;
    logic [15:0]    acg_nod;
    logic           acg_casel;
    logic [39:0]    acg_cad;
    logic           busy, done, err, tmo;

    always #5 clk = ~clk;

    nfc_command_dispatcher #(
        .NumberOfWays(W), .NumberOfExecutors(N), .TimeoutCycles(32'd16)
    ) dut (
        .iSystemClock(clk), .iReset(rst), .iCMDValid(cmd_valid), .oCMDReady(cmd_ready),
        .iExecStart(exec_start), .iExecCMDReady(exec_ready), .iExecLastStep(exec_last),
        .iExecCommand(exec_cmd), .iExecCommandOption(exec_opt), .iExecTargetWay(exec_way),
        .iExecNumOfData(exec_nod), .iExecCASelect(exec_casel), .iExecCAData(exec_cad),
        .oExecAbort(abort), .oACG_Command(acg_cmd), .oACG_CommandOption(acg_opt),
        .oACG_TargetWay(acg_way), .oACG_NumOfData(acg_nod), .oACG_CASelect(acg_casel),
        .oACG_CAData(acg_cad), .oOwner(owner), .oBusy(busy), .oCmdDone(done),
        .oCmdError(err), .oTimeout(tmo)
    );

    typedef struct packed {
        logic         done;
        logic         err;
        logic         tmo;
        logic [N-1:0] abort;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec  = 0;
    int  n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: every cycle with a pulse output must match the next expected event.
    always @(negedge clk) begin
        if (done || err || tmo) begin
            ev_t got;
            got = '{done: done, err: err, tmo: tmo, abort: abort};
            if (exp_q.size() == 0) check("unexpected_pulse", 64'(got), 64'h0);
            else                   check("pulse_event", 64'(got), 64'(exp_q.pop_front()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input logic d, input logic e, input logic t, input logic [N-1:0] a);
        ev_t ev;
        ev = '{done: d, err: e, tmo: t, abort: a};
        exp_q.push_back(ev);
    endtask

    task automatic issue(input logic [N-1:0] start);
        cmd_valid  = 1'b1;
        exec_start = start;
        tick(1);
        cmd_valid  = 1'b0;
        exec_start = '0;
    endtask

    task automatic finish_owner(input int idx);
        push_ev(1'b1, 1'b0, 1'b0, '0);
        exec_last[idx] = 1'b1;
        tick(1);
        exec_last = '0;
        tick(1);
        check("idle_after_done_busy", 64'(busy), 64'd0);
        check("idle_after_done_owner", 64'(owner), 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        exec_start = '0;
        exec_ready = '1;
        exec_last  = '0;
        exec_casel = 4'b1010;
        exec_cmd   = {8'h13, 8'h12, 8'h11, 8'h10};
        exec_opt   = {3'd3, 3'd2, 3'd1, 3'd0};
        exec_way   = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
        exec_nod   = {16'h0403, 16'h0302, 16'h0201, 16'h0100};
        exec_cad   = {40'h4400000044, 40'hEE00000000, 40'h2200000022, 40'h1100000011};

        tick(2);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_owner", 64'(owner), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_abort", 64'(abort), 64'd0);
        check("rst_acg_cmd", 64'(acg_cmd), 64'h00);
        check("rst_acg_casel", 64'(acg_casel), 64'd1);
        check("rst_acg_cad", 64'(acg_cad), 64'h0);
        rst = 1'b0;
        #1;
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        // Single start on executor 2.
        issue(4'b0100);
        check("t1_owner", 64'(owner), 64'b0100);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_cmd_ready", 64'(cmd_ready), 64'd0);
        check("t1_cad", 64'(acg_cad), 64'hEE00000000);
        check("t1_cmd", 64'(acg_cmd), 64'h12);
        check("t1_opt", 64'(acg_opt), 64'd2);
        check("t1_way", 64'(acg_way), 64'b0100);
        check("t1_nod", 64'(acg_nod), 64'h0302);
        check("t1_casel", 64'(acg_casel), 64'd0);
        push_ev(1'b1, 1'b0, 1'b0, '0);
        exec_last[2] = 1'b1;
        tick(1);
        exec_last = '0;
        check("done_state_cmd", 64'(acg_cmd), 64'h00);
        check("done_state_casel", 64'(acg_casel), 64'd1);
        tick(1);
        check("t1_idle_busy", 64'(busy), 64'd0);
        check("t1_idle_owner", 64'(owner), 64'd0);
        check("t1_idle_ready", 64'(cmd_ready), 64'd1);

        // Valid with no start: consumed as an error, stays idle.
        push_ev(1'b0, 1'b1, 1'b0, '0);
        issue(4'b0000);
        check("nostart_busy", 64'(busy), 64'd0);
        tick(1);
        check("nostart_busy2", 64'(busy), 64'd0);

        // Not every executor ready: command is not accepted.
        exec_ready = 4'b1110;
        #1;
        check("notready_cmd_ready", 64'(cmd_ready), 64'd0);
        issue(4'b0001);
        check("notready_busy", 64'(busy), 64'd0);
        exec_ready = '1;

        // Multiple starts: lowest wins and the error pulses.
        push_ev(1'b0, 1'b1, 1'b0, '0);
        issue(4'b0110);
        check("multi_owner", 64'(owner), 64'b0010);
        check("multi_cad", 64'(acg_cad), 64'h2200000022);
        finish_owner(1);

        // Owner 0: foreign LastStep, foreign slice changes and new starts are ignored.
        issue(4'b0001);
        exec_last[3] = 1'b1;
        exec_cad[40 +: 40] = 40'hDEADBEEF55;
        cmd_valid  = 1'b1;
        exec_start = 4'b0100;
        #1;
        check("active_cmd_ready", 64'(cmd_ready), 64'd0);
        tick(1);
        exec_last  = '0;
        cmd_valid  = 1'b0;
        exec_start = '0;
        check("foreign_last_busy", 64'(busy), 64'd1);
        check("foreign_last_owner", 64'(owner), 64'b0001);
        check("foreign_cad", 64'(acg_cad), 64'h1100000011);
        exec_cad[40 +: 40] = 40'h2200000022;
        finish_owner(0);

        // Reset during ACTIVE, coinciding with the owner's LastStep: no done pulse.
        issue(4'b0100);
        check("prereset_owner", 64'(owner), 64'b0100);
        rst          = 1'b1;
        exec_last[2] = 1'b1;
        tick(1);
        check("midreset_owner", 64'(owner), 64'd0);
        check("midreset_cmd", 64'(acg_cmd), 64'h00);
        check("midreset_casel", 64'(acg_casel), 64'd1);
        check("midreset_busy", 64'(busy), 64'd0);
        rst       = 1'b0;
        exec_last = '0;
        tick(2);
        check("postreset_ready", 64'(cmd_ready), 64'd1);

`ifdef NFC_DISPATCH_TIMEOUT_EN
        begin
            int waited;
            waited = 0;
            issue(4'b1000);
            push_ev(1'b0, 1'b0, 1'b1, 4'b1000);
            for (int i = 1; i <= 40; i++) begin
                tick(1);
                if (tmo) begin
                    waited = i;
                    break;
                end
            end
            check("timeout_latency", 64'(waited), 64'd16);
            tick(1);
            check("timeout_idle_busy", 64'(busy), 64'd0);
            check("timeout_idle_owner", 64'(owner), 64'd0);
        end
`endif

        tick(3);
        check("pending_events", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/nfc_command_dispatcher.md
# nfc_command_dispatcher

Arbitrates the single shared atomic command generator (ACG) port between NumberOfExecutors command executors (GetFeature, SetFeature, Reset, ReadPage, ...). Each executor decodes the host opcode itself and raises its start strobe. The dispatcher latches the single winning executor as owner and routes that owner's ACG request signals to the shared ACG. It releases ownership on the owner's last-step pulse. It sits between the host command front end and the per-command executors, directly upstream of the ACG.

## Interface
- NumberOfWays, 4, number of NAND ways (TargetWay width).
- NumberOfExecutors, 4, number of attached executors (N).
- TimeoutCycles, 32'd1_000_000, watchdog limit in cycles; used only with the timeout feature.
- iSystemClock  in  1  clock.
- iReset  in  1  synchronous, active-high reset.
- iCMDValid  in  1  host command valid (shared with executors).
- oCMDReady  out  1  host may present a command.
- iExecStart  in  N  per-executor oStart (opcode match & valid).
- iExecCMDReady  in  N  per-executor oCMDReady.
- iExecLastStep  in  N  per-executor oLastStep.
- iExecCommand  in  8N  ACG command, executor i at [8i+7:8i].
- iExecCommandOption  in  3N.
- iExecTargetWay  in  NumberOfWays*N.
- iExecNumOfData  in  16N.
- iExecCASelect  in  N.
- iExecCAData  in  40N.
- oExecAbort  out  N  one-cycle synchronous abort to the owner; timeout feature only, otherwise tied 0.
- oACG_Command  out  8; oACG_CommandOption out 3; oACG_TargetWay out NumberOfWays; oACG_NumOfData out 16; oACG_CASelect out 1; oACG_CAData out 40.
- oOwner  out  N  one-hot current owner, 0 when idle.
- oBusy  out  1  state != IDLE.
- oCmdDone  out  1  one-cycle pulse on owner completion.
- oCmdError  out  1  one-cycle pulse: unknown opcode or multiple starts.
- oTimeout  out  1  one-cycle pulse on watchdog expiry; tied 0 without the timeout feature.
- iACG_Ready, iACG_LastStep and iACG_ReadyBusy are not routed through this block. They are broadcast to all executors at the top level.

## Operation
- States: IDLE, ACTIVE, DONE.
- IDLE:
  - oCMDReady = &iExecCMDReady.
  - iCMDValid & oCMDReady & (iExecStart != 0): latch owner = lowest set index of iExecStart, go to ACTIVE.
  - More than one start bit set: the lowest index still wins, and oCmdError pulses.
  - iCMDValid & oCMDReady & (iExecStart == 0): oCmdError pulses, state stays IDLE, and the command is consumed.
- ACTIVE:
  - oCMDReady = 0.
  - All oACG_* are a combinational mux of the owner's slice, selected by the registered owner.
  - iExecLastStep[owner] = 1 → DONE.
  - LastStep from non-owners is ignored.
- DONE (one cycle):
  - oCmdDone = 1.
  - oACG_* forced to idle defaults.
  - Owner cleared; next state IDLE.
- Idle defaults, used in IDLE, DONE and during reset:
  - Command 8'h00, CommandOption 3'b000, TargetWay 0, NumOfData 16'h0000, CASelect 1, CAData 40'h0.
- Reset values: oCMDReady 0 during reset; oOwner 0, oBusy 0, all pulses 0, oExecAbort 0, ACG outputs at idle defaults.
- Reset mid-operation returns to IDLE immediately. No abort or done pulse is issued.

## Timing
- Cycle t: start accepted in IDLE.
- Cycle t+1: state ACTIVE, oOwner valid, oCMDReady 0. The owner's ACG slice reaches oACG_* with zero added latency.
- Owner LastStep at cycle k → DONE at k+1 → IDLE at k+2.
- A new command can be accepted at k+2 at the earliest.
- oCmdError is registered: it pulses in the cycle after the offending acceptance.
- Pulses are exactly one cycle wide.

## Configuration
- NFC_DISPATCH_TIMEOUT_EN defined:
  - A 32-bit counter clears on entry to ACTIVE and increments each ACTIVE cycle.
  - When the count reaches TimeoutCycles − 1 with no owner LastStep, the next cycle asserts oTimeout and oExecAbort[owner], and the state goes to DONE. oCmdDone is suppressed in this case.
  - LastStep and expiry in the same cycle: completion wins, no timeout is signalled.
- NFC_DISPATCH_TIMEOUT_EN undefined: no counter is built, and oTimeout and oExecAbort are constant 0.

## Structure
- Shared package nfc_pkg holds:
  - state encodings (one-hot, 3 bits);
  - ACG idle-default constants;
  - ACG field widths (8, 3, 16, 40).
- Sub-module nfc_lowest_onehot: parameterised priority encoder. It returns a one-hot lowest-set bit plus a multi-bit flag, and is used for owner selection.

## Test plan
- N=4, iExecStart=4'b0100 with valid and all executors ready:
  - oOwner=4'b0100 from t+1;
  - oACG_CAData equals slice 2 (e.g. 40'hEE00000000);
  - slice-2 LastStep → oCmdDone one cycle later, then IDLE.
- iCMDValid with iExecStart=0 → oCmdError one pulse, oBusy stays 0.
- iExecStart=4'b0110 → owner 4'b0010 and oCmdError pulse.
- While ACTIVE (owner 0):
  - LastStep on executor 3 is ignored;
  - executor 1 changing CAData does not affect oACG_CAData;
  - oCMDReady remains 0.
- iReset asserted during ACTIVE → next cycle oOwner=0, oACG_Command=0, oACG_CASelect=1, no oCmdDone.
- NFC_DISPATCH_TIMEOUT_EN with TimeoutCycles=16 and no LastStep → oTimeout and oExecAbort[owner] pulse 16 cycles after entry to ACTIVE, oCmdDone stays 0, then IDLE.
